// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings and the
// legality rule for the funct3/direction pair.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (we && f3[2]) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and sub-word merge for stores.
// Purely combinational, zero latency, no backpressure.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_data
);

  // The RAM returns the word starting at the byte address, so the wanted
  // bytes always sit in the low lanes.
  always_comb begin
    load_data = old_word;
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){old_word[7]}}, old_word[7:0]};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, old_word[7:0]};
      F3_H:    load_data = {{(DATA_WIDTH-16){old_word[15]}}, old_word[15:0]};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, old_word[15:0]};
      default: load_data = old_word;
    endcase
  end

  always_comb begin
    store_data = wdata;
    case (funct3[1:0])
      2'b00:   store_data = {old_word[DATA_WIDTH-1:8], wdata[7:0]};
      2'b01:   store_data = {old_word[DATA_WIDTH-1:16], wdata[15:0]};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller driving data_ram; sub-word stores use read-modify-write.
// Latency: illegal 1 cycle, load/SW 2 cycles, SB/SH 3 cycles; one request in flight.
// Response held until resp_ready; req_ready only in IDLE. MISALIGN_TRAP_EN traps misaligned H/W.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     Data_WE,
  output logic [ADDRESS_WIDTH-1:0] Data_addr,
  output logic [DATA_WIDTH-1:0]    Data_WD,
  input  logic [DATA_WIDTH-1:0]    Data_RD
);

  lsu_state_t            state, state_nxt;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  misalign;
  logic                  illegal;
  logic                  full_word_store;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_data;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign accept          = req_valid && req_ready;
  assign illegal         = f3_illegal(req_we, req_funct3) || misalign;
  assign full_word_store = req_we && (req_funct3 == F3_W);

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .funct3     (f3_q),
    .old_word   (Data_RD),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (illegal)              state_nxt = RESP;
          else if (full_word_store) state_nxt = WR;
          else                      state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data_WE is a flop so an async reset drops it without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q       <= 3'b000;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      Data_WE    <= 1'b0;
      Data_addr  <= '0;
      Data_WD    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      Data_WE <= (state_nxt == WR);
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q       <= req_funct3;
            we_q       <= req_we;
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= illegal;
            if (!illegal) begin
              Data_addr <= req_addr;
              if (full_word_store) Data_WD <= req_wdata;
            end
          end
        end
        RD: begin
          if (we_q) Data_WD    <= store_data;
          else      resp_rdata <= load_data;
        end
        WR:      resp_rdata <= '0;
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: resp_err <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller, the initiator side of data_ram's Data_* interface. Accepts one load/store request at a time from the execute stage. Performs byte/half loads with sign/zero extension. Performs sub-word stores by read-modify-write, because the RAM always writes four bytes. Returns the load result or store completion over a valid/ready response channel.

Parameters:
ADDRESS_WIDTH, 32, width of req_addr and Data_addr
DATA_WIDTH, 32, data width; only 32 supported (four 8-bit lanes)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_we  input  1  1=store, 0=load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  ADDRESS_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data; low bytes used for B/H
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  output  1  illegal access, no memory effect
Data_WE  output  1  RAM write enable, registered
Data_addr  output  ADDRESS_WIDTH  RAM byte address
Data_WD  output  DATA_WIDTH  RAM write data
Data_RD  input  DATA_WIDTH  RAM combinational read of bytes addr..addr+3, little-endian

Behaviour:
- Interface is one clock (clk) with asynchronous, active-high reset (rst). Reset forces state IDLE. All outputs are 0 except req_ready=1. A reset mid-operation drops Data_WE immediately and aborts the access with no partial write.
- States are IDLE, RD, WR, RESP. Accept occurs when req_valid && req_ready in IDLE. Request fields are captured on accept.
- Legality: store with funct3[2]=1, or funct3 in {011,110,111}, is illegal. An illegal request goes IDLE->RESP with resp_err=1, never touches the RAM, and has 1-cycle latency.
- Load path is IDLE->RD->RESP. In RD, Data_addr=captured addr and Data_RD is registered. Lane extraction always uses the low lanes, since the RAM returns the word starting at the byte address: B=sext(RD[7:0]), BU=zext(RD[7:0]), H=sext(RD[15:0]), HU=zext(RD[15:0]), W=RD. resp_valid is asserted 2 cycles after accept.
- SW path is IDLE->WR->RESP. Data_WE=1 for exactly one cycle with Data_WD=wdata.
- SB/SH path is IDLE->RD->WR->RESP. In RD the old word is captured. In WR, Data_WD={old[31:8],wdata[7:0]} for SB or {old[31:16],wdata[15:0]} for SH. Untouched bytes are rewritten unchanged.
- Data_addr holds the captured address in RD and WR, and holds its last value otherwise. Data_WE is 0 outside WR.
- RESP: resp_valid, resp_rdata and resp_err are stable until resp_ready. On handshake, go to IDLE. req_ready stays low in RESP, so there is no same-cycle accept; peak throughput is one request per 3 cycles (load/SW) or 4 cycles (SB/SH).
- Address wrap: the full address is passed through. The RAM's 8-bit index wraps; this unit does no bounds check.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: an H/HU/SH access with addr[0]=1, or a W/SW access with addr[1:0]!=0, is treated as illegal (resp_err=1, no RAM access, 1-cycle latency).
- Undefined: misaligned accesses proceed normally; the RAM's byte lanes handle any offset.

Decomposition:
- Package lsu_pkg holds the state enum (IDLE, RD, WR, RESP) and the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- One combinational sub-module, lsu_align, performs load extraction/extension and store merge given funct3, old word and wdata.

Test Plan:
- Preload mem[0x10..0x13]=BB,AA,99,88. LW 0x10 -> resp_rdata=0x8899AABB, resp_valid 2 cycles after accept, Data_WE never high.
- LB 0x13 -> 0xFFFFFF88. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899.
- SB 0x11 wdata=0x12345655 -> one Data_WE pulse, then LW 0x10 -> 0x889955BB. Bytes 0x12..0x14 unchanged.
- SH 0x12 wdata=0xDEADCAFE, then LW 0x10 -> 0xCAFE55BB. mem[0x14],mem[0x15] unchanged.
- funct3=011 load, and a store with funct3=100 -> resp_err=1 next cycle, resp_rdata=0, Data_WE stays 0. Hold resp_ready=0 for 5 cycles -> response stable, req_ready=0.
- Assert rst during WR of SW 0x20 -> Data_WE falls without a clock edge, mem[0x20..0x23] unchanged, req_ready=1. With MISALIGN_TRAP_EN: LW 0x11 -> resp_err=1.
